// File: rtl/xgmii_link_fault_monitor_pkg.sv
// Shared XGMII constants and link-fault encodings for the RX fault monitor.
package xgmii_link_fault_monitor_pkg;

    localparam logic [7:0]  XGMII_IDLE      = 8'h07;
    localparam logic [7:0]  XGMII_SEQ       = 8'h9C;
    localparam logic [7:0]  XGMII_LF        = 8'h01;
    localparam logic [7:0]  XGMII_RF        = 8'h02;

    // Two local-fault columns, lane 0 and lane 4, with their control bits.
    localparam logic [63:0] XGMII_LF_WORD   = 64'h0100009C0100009C;
    localparam logic [7:0]  XGMII_LF_CTRL   = 8'h11;

    localparam logic [63:0] XGMII_IDLE_WORD = {8{XGMII_IDLE}};
    localparam logic [7:0]  XGMII_IDLE_CTRL = 8'hFF;

    // Link status; LINK_OK doubles as "no sequence type" for the tracker.
    typedef enum logic [1:0] {
        LINK_OK     = 2'b00,
        LINK_LOCAL  = 2'b01,
        LINK_REMOTE = 2'b10
    } link_fault_e;

endpackage

// File: rtl/xgmii_fault_seq_decode.sv
// Classifies one 32-bit XGMII column as a local/remote fault ordered set or not.
module xgmii_fault_seq_decode
    import xgmii_link_fault_monitor_pkg::*;
(
    input  logic [31:0] col,
    input  logic [3:0]  ctrl,
    output logic        is_fault,
    output link_fault_e fault_type
);

    logic frame_ok;

    // Sequence framing: control only on byte 0, which carries 9C; bytes 1-2 zero.
    assign frame_ok = (ctrl == 4'b0001) && (col[7:0] == XGMII_SEQ) && (col[23:8] == 16'h0000);

    // Byte 3 selects fault type; reserved codes fall through as non-fault.
    always_comb begin
        is_fault   = 1'b0;
        fault_type = LINK_OK;
        if (frame_ok) begin
            if (col[31:24] == XGMII_LF) begin
                is_fault   = 1'b1;
                fault_type = LINK_LOCAL;
            end else if (col[31:24] == XGMII_RF) begin
                is_fault   = 1'b1;
                fault_type = LINK_REMOTE;
            end
        end
    end

endmodule

// File: rtl/xgmii_link_fault_monitor.sv
// XGMII RX link-fault monitor: 1-cycle pass-through, fault tracking, status and counters.
module xgmii_link_fault_monitor
    import xgmii_link_fault_monitor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned CTRL_WIDTH    = 8,
    parameter int unsigned COL_WINDOW    = 128,
    parameter int unsigned SEQ_THRESHOLD = 4,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_block_lock,
    input  logic [DATA_WIDTH-1:0] s_xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] s_xgmii_rxc,
    output logic [DATA_WIDTH-1:0] m_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] m_xgmii_rxc,
    output logic [1:0]            link_fault,
    output logic                  link_up,
    output logic                  fault_event,
    input  logic                  clear_counts,
    output logic [CNT_WIDTH-1:0]  local_fault_count,
    output logic [CNT_WIDTH-1:0]  remote_fault_count
);

    localparam int unsigned SEQ_W = $clog2(SEQ_THRESHOLD + 1);
    localparam int unsigned COL_W = $clog2(COL_WINDOW + 1);

    typedef struct packed {
        link_fault_e      lf;
        link_fault_e      seq_type;
        logic [SEQ_W-1:0] seq_cnt;
        logic [COL_W-1:0] col_cnt;
    } mon_t;

    mon_t        mon_q;
    mon_t        mid_c;
    mon_t        nxt_c;
    logic        evt_c;
    logic        f0;
    logic        f1;
    link_fault_e t0;
    link_fault_e t1;

    // Apply one column to the tracker state.
    function automatic mon_t apply_col(input mon_t s, input logic is_f, input link_fault_e t);
        mon_t r;
        r = s;
        if (is_f) begin
            if (t != s.seq_type) begin
                r.seq_type = t;
                r.seq_cnt  = SEQ_W'(1);
            end else if (s.seq_cnt < SEQ_W'(SEQ_THRESHOLD)) begin
                r.seq_cnt = s.seq_cnt + SEQ_W'(1);
            end
            r.col_cnt = '0;
            if (r.seq_cnt == SEQ_W'(SEQ_THRESHOLD)) begin
                r.lf = t;
            end
        end else begin
            r.col_cnt = s.col_cnt + COL_W'(1);
            if (r.col_cnt == COL_W'(COL_WINDOW)) begin
                r.col_cnt  = '0;
                r.seq_cnt  = '0;
                r.seq_type = LINK_OK;
                r.lf       = LINK_OK;
            end
        end
        return r;
    endfunction

    xgmii_fault_seq_decode u_dec_lane0 (
        .col        (s_xgmii_rxd[31:0]),
        .ctrl       (s_xgmii_rxc[3:0]),
        .is_fault   (f0),
        .fault_type (t0)
    );

    xgmii_fault_seq_decode u_dec_lane4 (
        .col        (s_xgmii_rxd[63:32]),
        .ctrl       (s_xgmii_rxc[7:4]),
        .is_fault   (f1),
        .fault_type (t1)
    );

    // Next state: lane 0 then lane 4; lock loss forces a declared local fault.
    always_comb begin
        mid_c = mon_q;
        nxt_c = mon_q;
        evt_c = 1'b0;
        mid_c = apply_col(mon_q, f0, t0);
        nxt_c = apply_col(mid_c, f1, t1);
        if (!rx_block_lock) begin
            nxt_c.lf       = LINK_LOCAL;
            nxt_c.seq_type = LINK_LOCAL;
            nxt_c.seq_cnt  = SEQ_W'(SEQ_THRESHOLD);
            nxt_c.col_cnt  = '0;
        end
        evt_c = (nxt_c.lf != LINK_OK) && (nxt_c.lf != mon_q.lf);
    end

    // Tracker state and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_q.lf       <= LINK_LOCAL;
            mon_q.seq_type <= LINK_OK;
            mon_q.seq_cnt  <= '0;
            mon_q.col_cnt  <= '0;
            link_up        <= 1'b0;
            fault_event    <= 1'b0;
        end else begin
            mon_q          <= nxt_c;
            link_up        <= rx_block_lock && (nxt_c.lf == LINK_OK);
            fault_event    <= evt_c;
        end
    end

    assign link_fault = mon_q.lf;

    // Data pass-through, replaced by local-fault columns while unlocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_xgmii_rxd <= XGMII_IDLE_WORD;
            m_xgmii_rxc <= XGMII_IDLE_CTRL;
        end else if (!rx_block_lock) begin
            m_xgmii_rxd <= XGMII_LF_WORD;
            m_xgmii_rxc <= XGMII_LF_CTRL;
        end else begin
            m_xgmii_rxd <= s_xgmii_rxd;
            m_xgmii_rxc <= s_xgmii_rxc;
        end
    end

    // Saturating fault-entry counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            local_fault_count  <= '0;
            remote_fault_count <= '0;
        end else if (clear_counts) begin
            local_fault_count  <= '0;
            remote_fault_count <= '0;
        end else if (evt_c) begin
            if (nxt_c.lf == LINK_LOCAL && local_fault_count != '1) begin
                local_fault_count <= local_fault_count + CNT_WIDTH'(1);
            end
            if (nxt_c.lf == LINK_REMOTE && remote_fault_count != '1) begin
                remote_fault_count <= remote_fault_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_xgmii_link_fault_monitor.sv
// Directed bench for the XGMII link-fault monitor with a data scoreboard.
module tb_xgmii_link_fault_monitor;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] LF_W   = 64'h0100009C0100009C;
    localparam logic [63:0] RF_W   = 64'h0200009C0200009C;
    localparam logic [63:0] ALT_W  = 64'h0200009C0100009C;
    localparam logic [63:0] RSV_W  = 64'h0300009C0300009C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_block_lock = 1'b1;
    logic [63:0] s_rxd = 64'h0707070707070707;
    logic [7:0]  s_rxc = 8'hFF;
    logic [63:0] m_rxd;
    logic [7:0]  m_rxc;
    logic [1:0]  link_fault;
    logic        link_up;
    logic        fault_event;
    logic        clear_counts = 1'b0;
    logic [15:0] local_cnt;
    logic [15:0] remote_cnt;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ev_seen = 0;
    int   ev_mark = 0;
    logic lf_bad  = 1'b0;

    xgmii_link_fault_monitor dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rx_block_lock      (rx_block_lock),
        .s_xgmii_rxd        (s_rxd),
        .s_xgmii_rxc        (s_rxc),
        .m_xgmii_rxd        (m_rxd),
        .m_xgmii_rxc        (m_rxc),
        .link_fault         (link_fault),
        .link_up            (link_up),
        .fault_event        (fault_event),
        .clear_counts       (clear_counts),
        .local_fault_count  (local_cnt),
        .remote_fault_count (remote_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push expected output data, then pop and compare after the edge.
    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic lk, input logic clr);
        exp_t e;
        s_rxd         = d;
        s_rxc         = c;
        rx_block_lock = lk;
        clear_counts  = clr;
        e.d = lk ? d : LF_W;
        e.c = lk ? c : 8'h11;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
        e = exp_q.pop_front();
        chk("m_xgmii_rxd", m_rxd, e.d);
        chk("m_xgmii_rxc", {56'h0, m_rxc}, {56'h0, e.c});
        if (fault_event === 1'b1) ev_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(IDLE_W, 8'hFF, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #12;
        chk("rst_rxd", m_rxd, IDLE_W);
        chk("rst_rxc", {56'h0, m_rxc}, 64'hFF);
        chk("rst_link_fault", {62'h0, link_fault}, 64'h1);
        chk("rst_link_up", {63'h0, link_up}, 64'h0);
        chk("rst_fault_event", {63'h0, fault_event}, 64'h0);
        chk("rst_local_cnt", {48'h0, local_cnt}, 64'h0);
        chk("rst_remote_cnt", {48'h0, remote_cnt}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 64 idle cycles clear the reset-time local fault
        ev_mark = ev_seen;
        idle(63);
        chk("idle63_link_fault", {62'h0, link_fault}, 64'h1);
        chk("idle63_link_up", {63'h0, link_up}, 64'h0);
        idle(1);
        chk("idle64_link_fault", {62'h0, link_fault}, 64'h0);
        chk("idle64_link_up", {63'h0, link_up}, 64'h1);
        chk("idle_no_events", 64'(ev_seen - ev_mark), 64'h0);

        // Two cycles of local fault sequences
        ev_mark = ev_seen;
        step(LF_W, 8'h11, 1'b1, 1'b0);
        chk("lf1_link_fault", {62'h0, link_fault}, 64'h0);
        step(LF_W, 8'h11, 1'b1, 1'b0);
        chk("lf2_link_fault", {62'h0, link_fault}, 64'h1);
        chk("lf2_fault_event", {63'h0, fault_event}, 64'h1);
        chk("lf2_link_up", {63'h0, link_up}, 64'h0);
        chk("lf2_local_cnt", {48'h0, local_cnt}, 64'h1);
        idle(1);
        chk("lf_event_pulse", {63'h0, fault_event}, 64'h0);
        idle(62);
        chk("lf_hold63", {62'h0, link_fault}, 64'h1);
        idle(1);
        chk("lf_clear64", {62'h0, link_fault}, 64'h0);
        chk("lf_one_event", 64'(ev_seen - ev_mark), 64'h1);

        // Two cycles of remote fault sequences, then idle window
        step(RF_W, 8'h11, 1'b1, 1'b0);
        step(RF_W, 8'h11, 1'b1, 1'b0);
        chk("rf_link_fault", {62'h0, link_fault}, 64'h2);
        chk("rf_fault_event", {63'h0, fault_event}, 64'h1);
        chk("rf_remote_cnt", {48'h0, remote_cnt}, 64'h1);
        chk("rf_local_cnt", {48'h0, local_cnt}, 64'h1);
        idle(63);
        chk("rf_hold63", {62'h0, link_fault}, 64'h2);
        idle(1);
        chk("rf_clear64", {62'h0, link_fault}, 64'h0);
        chk("rf_link_up", {63'h0, link_up}, 64'h1);

        // Alternating local/remote columns never reach threshold
        ev_mark = ev_seen;
        for (int i = 0; i < 100; i++) begin
            step(ALT_W, 8'h11, 1'b1, 1'b0);
            if (link_fault !== 2'b00) lf_bad = 1'b1;
        end
        chk("alt_link_fault_stable", {63'h0, lf_bad}, 64'h0);
        chk("alt_no_events", 64'(ev_seen - ev_mark), 64'h0);

        // Reserved byte3 and bad control columns are not counted
        step(LF_W, 8'h11, 1'b1, 1'b0);
        step(RSV_W, 8'h11, 1'b1, 1'b0);
        chk("rsv_not_counted", {62'h0, link_fault}, 64'h0);
        step(LF_W, 8'h1F, 1'b1, 1'b0);
        chk("rxc1f_not_counted", {62'h0, link_fault}, 64'h0);
        step(LF_W, 8'h11, 1'b1, 1'b0);
        chk("seq4_link_fault", {62'h0, link_fault}, 64'h1);
        chk("seq4_local_cnt", {48'h0, local_cnt}, 64'h2);
        idle(64);
        chk("seq4_cleared", {62'h0, link_fault}, 64'h0);

        // One cycle of lock loss while OK
        ev_mark = ev_seen;
        step(IDLE_W, 8'hFF, 1'b0, 1'b0);
        chk("lock_link_fault", {62'h0, link_fault}, 64'h1);
        chk("lock_link_up", {63'h0, link_up}, 64'h0);
        chk("lock_fault_event", {63'h0, fault_event}, 64'h1);
        chk("lock_local_cnt", {48'h0, local_cnt}, 64'h3);
        idle(63);
        chk("lock_hold63", {62'h0, link_fault}, 64'h1);
        idle(1);
        chk("lock_clear64", {62'h0, link_fault}, 64'h0);
        chk("lock_one_event", 64'(ev_seen - ev_mark), 64'h1);

        // Clear coinciding with a fault event
        step(LF_W, 8'h11, 1'b1, 1'b0);
        step(LF_W, 8'h11, 1'b1, 1'b1);
        chk("clr_fault_event", {63'h0, fault_event}, 64'h1);
        chk("clr_local_cnt", {48'h0, local_cnt}, 64'h0);
        chk("clr_remote_cnt", {48'h0, remote_cnt}, 64'h0);

        // Async reset mid-fault, checked before any clock edge
        rst_n = 1'b0;
        #2;
        chk("arst_rxd", m_rxd, IDLE_W);
        chk("arst_rxc", {56'h0, m_rxc}, 64'hFF);
        chk("arst_link_fault", {62'h0, link_fault}, 64'h1);
        chk("arst_fault_event", {63'h0, fault_event}, 64'h0);
        chk("arst_link_up", {63'h0, link_up}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
